risc_controller: RTL and testbench

- Instruction sequencer for the simple RISC core; an 8-phase Moore-style controller.
- Sits directly upstream of program_counter and drives its ld_pc/inc_pc strobes. Also drives the address mux select, memory read/write, the IR load and the accumulator load.
- Consumes the 3-bit opcode from the instruction register and the accumulator zero flag. The address field of the IR feeds pc_in externally; this block does not handle it.

---
 rtl/risc_controller.sv | 147 ++++++++++++++
 tb/tb_risc_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/risc_controller.sv
// Eight-phase instruction sequencer for the simple RISC core.
// Drives the fetch/execute strobes for PC, IR, accumulator and memory from (phase, opcode, zero).
module risc_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic [2:0] phase,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       halt,
   output logic       data_e,
   output logic       ld_ac,
   output logic       wr
);

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   localparam logic [2:0] PH_INST_ADDR  = 3'd0;
   localparam logic [2:0] PH_INST_FETCH = 3'd1;
   localparam logic [2:0] PH_INST_LOAD  = 3'd2;
   localparam logic [2:0] PH_IDLE       = 3'd3;
   localparam logic [2:0] PH_OP_ADDR    = 3'd4;
   localparam logic [2:0] PH_OP_FETCH   = 3'd5;
   localparam logic [2:0] PH_ALU_OP     = 3'd6;
   localparam logic [2:0] PH_STORE      = 3'd7;

   logic [2:0] phase_r;
   logic [2:0] phase_nxt_s;
   logic       halted_r;
   logic       halted_nxt_s;
   logic       aluop_s;

   // Phase counter and sticky halted flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         phase_r  <= 3'd0;
         halted_r <= 1'b0;
      end else begin
         phase_r  <= phase_nxt_s;
         halted_r <= halted_nxt_s;
      end
   end

   // Next phase: advance when enabled; HLT parks the sequencer in OP_ADDR
   always_comb begin
      phase_nxt_s  = phase_r;
      halted_nxt_s = halted_r;
      if (ena && !halted_r) begin
         if ((phase_r == PH_OP_ADDR) && (opcode == OP_HLT)) begin
            halted_nxt_s = 1'b1;
         end else begin
            phase_nxt_s = phase_r + 3'd1;
         end
      end else begin
         phase_nxt_s = phase_r;
      end
   end

   // Opcodes that read an operand and write the accumulator
   always_comb begin
      case (opcode)
         OP_ADD, OP_AND, OP_XOR, OP_LDA: aluop_s = 1'b1;
         default:                        aluop_s = 1'b0;
      endcase
   end

   // Moore output decode; strobes are gated by ena so a held cycle never double-fires
   always_comb begin
      phase  = 3'd0;
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      halt   = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      if (!rst) begin
         phase = 3'd0;
      end else if (halted_r) begin
         phase = phase_r;
         halt  = 1'b1;
      end else begin
         phase = phase_r;
         case (phase_r)
            PH_INST_ADDR: begin
               sel = 1'b1;
            end
            PH_INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
               inc_pc = 1'b1;
               halt   = (opcode == OP_HLT);
            end
            PH_OP_FETCH: begin
               rd = aluop_s;
            end
            PH_ALU_OP: begin
               rd     = aluop_s;
               inc_pc = (opcode == OP_SKZ) && zero;
               ld_pc  = (opcode == OP_JMP);
               data_e = (opcode == OP_STO);
            end
            PH_STORE: begin
               rd     = aluop_s;
               ld_ac  = aluop_s;
               ld_pc  = (opcode == OP_JMP);
               wr     = (opcode == OP_STO);
               data_e = (opcode == OP_STO);
            end
            default: begin
               sel = 1'b0;
            end
         endcase
         if (!ena) begin
            ld_ir  = 1'b0;
            inc_pc = 1'b0;
            ld_pc  = 1'b0;
            ld_ac  = 1'b0;
            wr     = 1'b0;
         end else begin
            wr = wr;
         end
      end
   end

endmodule

// File: tb/tb_risc_controller.sv
// Scoreboarded bench for risc_controller with a small program counter attached to its strobes.
module tb_risc_controller;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [2:0] opcode;
   logic       zero;
   logic [2:0] phase;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr;

   logic [4:0] pc_r;
   logic [4:0] addr;

   int total_cnt;
   int bad_cnt;

   logic [11:0] exp_q[$];

   logic [2:0] m_phase;
   logic       m_halted;

   risc_controller dut (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .opcode (opcode),
      .zero   (zero),
      .phase  (phase),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .halt   (halt),
      .data_e (data_e),
      .ld_ac  (ld_ac),
      .wr     (wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program counter driven by the DUT strobes, fed from the IR address field
   always @(posedge clk) begin
      if (!rst) begin
         pc_r <= 5'd0;
      end else if (ld_pc) begin
         pc_r <= addr;
      end else if (inc_pc) begin
         pc_r <= pc_r + 5'd1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected output vector {phase,sel,rd,ld_ir,inc_pc,ld_pc,halt,data_e,ld_ac,wr}
   function automatic logic [11:0] expect_out(input logic [2:0] ph, input logic hl,
                                              input logic r, input logic en,
                                              input logic [2:0] op, input logic z);
      logic alu, e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_halt, e_de, e_ldac, e_wr;
      alu    = (op >= 3'd2) && (op <= 3'd5);
      e_sel  = (ph <= 3'd3);
      e_rd   = ((ph >= 3'd1) && (ph <= 3'd3)) || ((ph >= 3'd5) && alu);
      e_ldir = en && ((ph == 3'd2) || (ph == 3'd3));
      e_inc  = en && ((ph == 3'd4) || ((ph == 3'd6) && (op == 3'd1) && z));
      e_ldpc = en && (op == 3'd7) && (ph >= 3'd6);
      e_halt = (ph == 3'd4) && (op == 3'd0);
      e_de   = (op == 3'd6) && (ph >= 3'd6);
      e_ldac = en && (ph == 3'd7) && alu;
      e_wr   = en && (ph == 3'd7) && (op == 3'd6);
      if (!r) return 12'h000;
      if (hl) return {ph, 9'b000001000};
      return {ph, e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_halt, e_de, e_ldac, e_wr};
   endfunction

   // One clock: drive inputs, push expectation, compare away from the edge, advance model
   task automatic cycle(input logic r, input logic en, input logic [2:0] op, input logic z,
                        input string tag);
      logic [11:0] got;
      logic [11:0] exp;
      @(negedge clk);
      rst    = r;
      ena    = en;
      opcode = op;
      zero   = z;
      exp_q.push_back(expect_out(m_phase, m_halted, r, en, op, z));
      #1;
      got = {phase, sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr};
      if (exp_q.size() == 0) begin
         check_eq("queue_underflow", 16'd0, 16'd1);
      end else begin
         exp = exp_q.pop_front();
         check_eq(tag, {4'd0, got}, {4'd0, exp});
      end
      @(posedge clk);
      if (!r) begin
         m_phase  = 3'd0;
         m_halted = 1'b0;
      end else if (en && !m_halted) begin
         if ((m_phase == 3'd4) && (op == 3'd0)) m_halted = 1'b1;
         else m_phase = m_phase + 3'd1;
      end
   endtask

   task automatic run_instr(input logic [2:0] op, input logic z, input string tag);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, op, z, tag);
   endtask

   initial begin
      logic [4:0] pc_start;
      total_cnt = 0;
      bad_cnt   = 0;
      m_phase   = 3'd0;
      m_halted  = 1'b0;
      rst = 1'b0; ena = 1'b1; opcode = 3'd2; zero = 1'b0; addr = 5'd0;

      cycle(1'b0, 1'b1, 3'd2, 1'b0, "reset0");
      cycle(1'b0, 1'b1, 3'd2, 1'b0, "reset1");

      run_instr(3'd2, 1'b0, "add");
      check_eq("add_wrap_phase", {13'd0, m_phase}, 16'd0);
      run_instr(3'd6, 1'b0, "sto");
      run_instr(3'd3, 1'b1, "and");
      run_instr(3'd5, 1'b0, "lda");

      pc_start = pc_r;
      run_instr(3'd1, 1'b1, "skz_taken");
      check_eq("skz_taken_pc", {11'd0, pc_r}, {11'd0, pc_start + 5'd2});
      pc_start = pc_r;
      run_instr(3'd1, 1'b0, "skz_nop");
      check_eq("skz_nop_pc", {11'd0, pc_r}, {11'd0, pc_start + 5'd1});

      addr = 5'd15;
      run_instr(3'd7, 1'b0, "jmp");
      check_eq("jmp_pc", {11'd0, pc_r}, 16'd15);
      addr = 5'd0;

      // ena hold in phase 2
      cycle(1'b1, 1'b1, 3'd4, 1'b0, "hold_pre");
      cycle(1'b1, 1'b1, 3'd4, 1'b0, "hold_pre");
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 3'd4, 1'b0, "hold_ena0");
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 3'd4, 1'b0, "hold_resume");

      // reset in phase 6 of JMP
      addr = 5'd9;
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 3'd7, 1'b0, "jmp_abort");
      cycle(1'b0, 1'b1, 3'd7, 1'b0, "jmp_abort_rst");
      cycle(1'b1, 1'b1, 3'd7, 1'b0, "jmp_abort_after");
      check_eq("jmp_abort_pc", {11'd0, pc_r}, 16'd0);

      // HLT from a clean start: PC ends at HLT address + 1
      cycle(1'b0, 1'b1, 3'd0, 1'b0, "hlt_rst");
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 3'd0, 1'b0, "hlt_run");
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'b1, "halted");
      check_eq("hlt_pc", {11'd0, pc_r}, 16'd1);
      cycle(1'b0, 1'b1, 3'd2, 1'b0, "hlt_clear_rst");
      cycle(1'b1, 1'b1, 3'd2, 1'b0, "hlt_cleared");

      // Random mix, including holds and occasional resets
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "random");
      end

      check_eq("queue_drained", 16'(exp_q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
